// File: rtl/uart_rx_pkg.sv
// Shared constants and FSM state type for the UART receive engine.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word fall-through head and fill level.
// A push while full only lands when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (level == '0);
    assign full  = (level == LEVEL_W'(DEPTH));
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// 16x-oversampling UART receiver with FIFO, sticky errors and interrupt.
// Define UART_RX_PARITY_EN for 8E1 frames with a Parity_Err_o flag.
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = 5
) (
    input  logic               CLK_IP_i,
    input  logic               RST_IP_N_i,
    input  logic               UART_SIN_i,
    input  logic [15:0]        Baud_Div_i,
    input  logic               Rx_Rd_i,
    input  logic [LEVEL_W-1:0] Rx_Thresh_i,
    input  logic               Err_Clr_i,
    output logic [7:0]         Rx_Dat_o,
    output logic               Rx_Empty_o,
    output logic               Rx_Full_o,
    output logic [LEVEL_W-1:0] Rx_Level_o,
    output logic               Frame_Err_o,
    output logic               Overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic               Parity_Err_o,
`endif
    output logic               Rx_Intr_o
);

    rx_state_t   state;
    logic [1:0]  sync;
    logic        sin;
    logic        sin_prev;
    logic [15:0] div_cnt;
    logic [15:0] div_load;
    logic        tick;
    logic [3:0]  phase;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        stop_tick;
    logic        push;
    logic        frame_set;
    logic        ovr_set;
    logic        err_any;
    logic        lvl_hit;

    assign sin      = sync[1];
    assign div_load = (Baud_Div_i == 16'd0) ? 16'd1 : Baud_Div_i;
    assign tick     = (div_cnt == 16'd0);

    always_ff @(posedge CLK_IP_i or negedge RST_IP_N_i) begin
        if (!RST_IP_N_i) begin
            sync     <= 2'b11;
            sin_prev <= 1'b1;
            div_cnt  <= '0;
        end else begin
            sync     <= {sync[0], UART_SIN_i};
            sin_prev <= sin;
            div_cnt  <= tick ? div_load - 16'd1 : div_cnt - 16'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_set;
    assign par_set = (state == ST_PARITY) && tick &&
                     (phase == 4'(OVERSAMPLE - 1)) && (^{shreg, sin});
`else
    logic par_bad;
    assign par_bad = 1'b0;
`endif

    assign stop_tick = (state == ST_STOP) && tick &&
                       (phase == 4'(OVERSAMPLE - 1));
    assign push      = stop_tick && sin && !par_bad;
    assign frame_set = stop_tick && !sin;
    assign ovr_set   = push && Rx_Full_o && !Rx_Rd_i;

    // phase wraps 15->0 on its own, so every mid-bit sample is 16 ticks apart
    always_ff @(posedge CLK_IP_i or negedge RST_IP_N_i) begin
        if (!RST_IP_N_i) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sin_prev && !sin) begin
                        state <= ST_START;
                        phase <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (phase == 4'(MID_SAMPLE - 1)) begin
                            phase   <= '0;
                            bit_cnt <= '0;
                            state   <= sin ? ST_IDLE : ST_DATA;
                        end else begin
                            phase <= phase + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        if (phase == 4'(OVERSAMPLE - 1)) begin
                            shreg   <= {sin, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        if (phase == 4'(OVERSAMPLE - 1)) begin
                            par_bad <= ^{shreg, sin};
                            state   <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        if (phase == 4'(OVERSAMPLE - 1)) begin
                            state <= sin ? ST_IDLE : ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (sin) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk   (CLK_IP_i),
        .rst_n (RST_IP_N_i),
        .push  (push),
        .pop   (Rx_Rd_i),
        .din   (shreg),
        .dout  (Rx_Dat_o),
        .empty (Rx_Empty_o),
        .full  (Rx_Full_o),
        .level (Rx_Level_o)
    );

`ifdef UART_RX_PARITY_EN
    assign err_any = Frame_Err_o || Overrun_o || Parity_Err_o;
`else
    assign err_any = Frame_Err_o || Overrun_o;
`endif
    assign lvl_hit = (Rx_Thresh_i != '0) && (Rx_Level_o >= Rx_Thresh_i);

    always_ff @(posedge CLK_IP_i or negedge RST_IP_N_i) begin
        if (!RST_IP_N_i) begin
            Frame_Err_o <= 1'b0;
            Overrun_o   <= 1'b0;
            Rx_Intr_o   <= 1'b0;
        end else begin
            Frame_Err_o <= frame_set || (Frame_Err_o && !Err_Clr_i);
            Overrun_o   <= ovr_set || (Overrun_o && !Err_Clr_i);
            Rx_Intr_o   <= lvl_hit || err_any;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK_IP_i or negedge RST_IP_N_i) begin
        if (!RST_IP_N_i) begin
            Parity_Err_o <= 1'b0;
        end else begin
            Parity_Err_o <= par_set || (Parity_Err_o && !Err_Clr_i);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine in its default 8N1 build.
// Frames are driven bit by bit; expected values are hand-derived.
module tb_uart_rx_engine;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic [15:0] baud_div;
    logic       rd;
    logic [4:0] thresh;
    logic       err_clr;
    logic [7:0] dat;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       frame_err;
    logic       overrun;
    logic       intr;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_engine #(
        .FIFO_DEPTH (16),
        .LEVEL_W    (5)
    ) dut (
        .CLK_IP_i    (clk),
        .RST_IP_N_i  (rst_n),
        .UART_SIN_i  (sin),
        .Baud_Div_i  (baud_div),
        .Rx_Rd_i     (rd),
        .Rx_Thresh_i (thresh),
        .Err_Clr_i   (err_clr),
        .Rx_Dat_o    (dat),
        .Rx_Empty_o  (empty),
        .Rx_Full_o   (full),
        .Rx_Level_o  (level),
        .Frame_Err_o (frame_err),
        .Overrun_o   (overrun),
        .Rx_Intr_o   (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bits(input int nbits);
        repeat (nbits * 16 * int'(baud_div)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        sin = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            sin = d[i];
            wait_bits(1);
        end
        sin = stop;
        wait_bits(1);
        sin = 1'b1;
        wait_bits(1);
    endtask

    task automatic read_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_dat"}, 32'(dat), 32'h00);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
        check({tag, "_intr"}, 32'(intr), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sin      = 1'b1;
        baud_div = 16'd2;
        rd       = 1'b0;
        thresh   = 5'd0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single byte at divider 2
        send_byte(8'hA5, 1'b1);
        check("a5_empty", 32'(empty), 32'd0);
        check("a5_dat", 32'(dat), 32'hA5);
        check("a5_level", 32'(level), 32'd1);
        read_one();
        check("a5_rd_empty", 32'(empty), 32'd1);
        check("a5_rd_level", 32'(level), 32'd0);

        // short low glitch is rejected at the start-bit sample
        baud_div = 16'd4;
        sin = 1'b0;
        repeat (20) @(negedge clk);
        sin = 1'b1;
        wait_bits(2);
        check("gl_empty", 32'(empty), 32'd1);
        check("gl_ferr", 32'(frame_err), 32'd0);
        check("gl_ovr", 32'(overrun), 32'd0);
        send_byte(8'h11, 1'b1);
        check("gl_next_dat", 32'(dat), 32'h11);
        check("gl_next_level", 32'(level), 32'd1);
        read_one();

        // framing error
        baud_div = 16'd2;
        send_byte(8'h3C, 1'b0);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_empty", 32'(empty), 32'd1);
        check("fe_intr", 32'(intr), 32'd1);
        clear_errs();
        check("fe_clr_flag", 32'(frame_err), 32'd0);
        @(negedge clk);
        check("fe_clr_intr", 32'(intr), 32'd0);

        // overflow: 17 bytes, no reads
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
        end
        check("ov_level", 32'(level), 32'd16);
        check("ov_full", 32'(full), 32'd1);
        check("ov_flag", 32'(overrun), 32'd1);
        check("ov_head", 32'(dat), 32'h00);
        for (int i = 0; i < 16; i++) begin
            check("ov_read", 32'(dat), 32'(i));
            read_one();
        end
        check("ov_drained", 32'(empty), 32'd1);
        read_one();
        check("ov_rd_empty_lvl", 32'(level), 32'd0);
        clear_errs();
        @(negedge clk);
        check("ov_clr_intr", 32'(intr), 32'd0);

        // level threshold interrupt
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h40 + 8'(i), 1'b1);
        end
        check("th_below", 32'(intr), 32'd0);
        send_byte(8'h43, 1'b1);
        check("th_level", 32'(level), 32'd4);
        check("th_hit", 32'(intr), 32'd1);
        read_one();
        @(negedge clk);
        check("th_fall", 32'(intr), 32'd0);
        thresh = 5'd0;
        repeat (3) read_one();
        check("th_drained", 32'(empty), 32'd1);

        // reset during data bit 3
        sin = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 3; i++) begin
            sin = i[0];
            wait_bits(1);
        end
        sin = 1'b1;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid");
        sin = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_bits(2);
        check("mid_post_empty", 32'(empty), 32'd1);
        check("mid_post_ferr", 32'(frame_err), 32'd0);
        send_byte(8'h5A, 1'b1);
        check("mid_5a_dat", 32'(dat), 32'h5A);
        check("mid_5a_level", 32'(level), 32'd1);
        check("mid_5a_ferr", 32'(frame_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
